// File: rtl/dqs_cal_pkg.sv
// Shared types and constants for the DQS input-offset calibration block.
// DQS_CAL_MAJORITY_EN selects majority voting over 2^SAMPLES_LOG2 samples per code.
package dqs_cal_pkg;

`ifdef DQS_CAL_MAJORITY_EN
  localparam bit MAJORITY_EN = 1'b1;
`else
  localparam bit MAJORITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    EVAL   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [3:0]        OSC_ZERO = 4'b1000;
  localparam logic signed [3:0] IDX_MIN  = -4'sd7;
  localparam logic signed [3:0] IDX_MAX  = 4'sd7;

  // Sign-magnitude OSC encoding: bit 3 set means a positive (or zero) offset.
  function automatic logic [3:0] idx_to_osc(input logic signed [3:0] idx);
    logic [3:0] mag;
    if (idx < 0) mag = 4'(-idx);
    else         mag = 4'(idx);
    return {~idx[3], mag[2:0]};
  endfunction

endpackage

// File: rtl/dqs_offset_cal_if.sv
// Control handshake plus buffer-side OSC/OSC_EN/O signals of the offset calibrator.
interface dqs_offset_cal_if;
  logic       start;
  logic       buf_o;
  logic [3:0] osc;
  logic [1:0] osc_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cal_code;

  modport master (
    output start, buf_o,
    input  osc, osc_en, busy, done, err, cal_code
  );

  modport slave (
    input  start, buf_o,
    output osc, osc_en, busy, done, err, cal_code
  );
endinterface

// File: rtl/dqs_cal_vote.sv
// Per-code sample counter and ones counter with a strict-majority decision.
// With LOG2=0 it degenerates to a single registered sample.
module dqs_cal_vote #(
  parameter int LOG2 = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic last,
  output logic vote
);

  localparam int            W        = LOG2 + 1;
  localparam logic [W-1:0]  LAST_CNT = W'((1 << LOG2) - 1);
  localparam logic [W-1:0]  HALF     = W'((1 << LOG2) / 2);

  // One extra bit so a full run of ones cannot wrap.
  logic [W-1:0] sample_cnt;
  logic [W-1:0] ones;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      ones       <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      ones       <= '0;
    end else if (en) begin
      sample_cnt <= sample_cnt + W'(1);
      ones       <= ones + W'(d);
    end
  end

  assign last = (sample_cnt == LAST_CNT);
  assign vote = (ones > HALF);

endmodule

// File: rtl/dqs_offset_cal.sv
// Offset calibration controller for one IOBUFDSE3 receiver: sweeps OSC from -7 to +7
// and keeps the lowest code where O reads 1. Majority voting via DQS_CAL_MAJORITY_EN.
module dqs_offset_cal
  import dqs_cal_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES_LOG2  = 3
) (
  input logic             clk,
  input logic             rst,
  dqs_offset_cal_if.slave bus
);

  localparam int            VOTE_LOG2   = MAJORITY_EN ? SAMPLES_LOG2 : 0;
  localparam int            SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t            state;
  logic signed [3:0] idx;
  logic [SW-1:0]     settle_cnt;
  logic [3:0]        osc_q;
  logic [1:0]        osc_en_q;
  logic [3:0]        cal_q;
  logic [3:0]        cal_code_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        sync_q;
  logic              buf_sync;
  logic              vote_last;
  logic              vote;

  // buf_o is asynchronous to clk, so it passes through two flops before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      // NOTE: flops use <= so every register samples the values from before the edge.
      sync_q <= {sync_q[0], bus.buf_o};
    end
  end

  assign buf_sync = sync_q[1];

  dqs_cal_vote #(
    .LOG2 (VOTE_LOG2)
  ) u_vote (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == SETTLE),
    .en   (state == SAMPLE),
    .d    (buf_sync),
    .last (vote_last),
    .vote (vote)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= IDX_MIN;
      settle_cnt <= '0;
      osc_q      <= OSC_ZERO;
      osc_en_q   <= 2'b00;
      cal_q      <= OSC_ZERO;
      cal_code_q <= OSC_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx        <= IDX_MIN;
            osc_q      <= idx_to_osc(IDX_MIN);
            osc_en_q   <= 2'b11;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          else                           settle_cnt <= settle_cnt + SW'(1);
        end
        SAMPLE: begin
          if (vote_last) state <= EVAL;
        end
        EVAL: begin
          // A 1 already at -7 means the edge lies below the sweep range.
          if (vote) begin
            cal_q <= idx_to_osc(idx);
            if (idx == IDX_MIN) err_q <= 1'b1;
            state <= FINISH;
          end else if (idx == IDX_MAX) begin
            cal_q <= idx_to_osc(IDX_MAX);
            err_q <= 1'b1;
            state <= FINISH;
          end else begin
            idx        <= idx + 4'sd1;
            osc_q      <= idx_to_osc(idx + 4'sd1);
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        FINISH: begin
          osc_q      <= cal_q;
          cal_code_q <= cal_q;
          osc_en_q   <= 2'b00;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.osc      = osc_q;
  assign bus.osc_en   = osc_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.cal_code = cal_code_q;

endmodule

// File: tb/tb_dqs_offset_cal.sv
// Randomized self-checking bench for dqs_offset_cal with a behavioural receiver model
// and a cycle-level reference model of the sweep timing.
module tb_dqs_offset_cal;

  localparam int SETTLE = 16;
  localparam int LOG2   = 3;
`ifdef DQS_CAL_MAJORITY_EN
  localparam int PER  = SETTLE + (1 << LOG2) + 1;
  localparam int LAT1 = 151;
  localparam int LAT2 = 276;
  localparam int LAT3 = 26;
  localparam int LAT4 = 376;
`else
  localparam int PER  = SETTLE + 2;
  localparam int LAT1 = 109;
  localparam int LAT2 = 199;
  localparam int LAT3 = 19;
  localparam int LAT4 = 271;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sim_offset = 0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dqs_offset_cal_if bus ();

  dqs_offset_cal #(
    .SETTLE_CYCLES (SETTLE),
    .SAMPLES_LOG2  (LOG2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] map_code(input int idx);
    if (idx < 0) return {1'b0, 3'(-idx)};
    return {1'b1, 3'(idx)};
  endfunction

  // Receiver stand-in: each offset code step moves the input offset by 5 units.
  function automatic logic buf_model(input logic [3:0] osc, input logic [1:0] en, input int s);
    int idx;
    if (en != 2'b11) return 1'b0;
    idx = int'(osc[2:0]);
    if (!osc[3]) idx = -idx;
    return (s + 5 * idx) > 0;
  endfunction

  assign bus.buf_o = buf_model(bus.osc, bus.osc_en, sim_offset);

  function automatic void predict(input int s, output int n, output logic [3:0] cal, output logic err);
    n   = 15;
    cal = map_code(7);
    err = 1'b1;
    for (int i = -7; i <= 7; i++) begin
      if (s + 5 * i > 0) begin
        n   = i + 8;
        cal = map_code(i);
        err = (i == -7);
        return;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since start accept plus the predicted sweep outcome.
  bit         m_active  = 1'b0;
  bit         m_done    = 1'b0;
  int         m_k       = 0;
  int         m_n       = 1;
  logic [3:0] m_cal     = 4'b1000;
  logic       m_err     = 1'b0;
  logic [3:0] m_new_cal = 4'b1000;
  logic       m_new_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      m_cal    = 4'b1000;
      m_err    = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == m_n * PER + 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_cal    = m_new_cal;
          m_err    = m_new_err;
        end
      end else if (bus.start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_err    = 1'b0;
        predict(sim_offset, m_n, m_new_cal, m_new_err);
      end
    end
  end

  logic [3:0] e_osc;
  logic [1:0] e_osc_en;
  logic       e_busy;
  logic       e_err;
  int         e_code;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_active) begin
        e_code = m_k / PER;
        if (e_code > m_n - 1) e_code = m_n - 1;
        e_osc    = map_code(-7 + e_code);
        e_osc_en = 2'b11;
        e_busy   = 1'b1;
        e_err    = (m_k >= m_n * PER) ? m_new_err : 1'b0;
      end else begin
        e_osc    = m_cal;
        e_osc_en = 2'b00;
        e_busy   = 1'b0;
        e_err    = m_err;
      end
      check("osc", bus.osc, e_osc);
      check("osc_en", bus.osc_en, e_osc_en);
      check("osc_en_legal", (bus.osc_en == 2'b01) || (bus.osc_en == 2'b10), 0);
      check("busy", bus.busy, e_busy);
      check("done", bus.done, m_done);
      check("err", bus.err, e_err);
      check("cal_code", bus.cal_code, m_cal);
    end
  end

  task automatic run_cal(input int s, input logic [3:0] exp_cal, input logic exp_err,
                         input int exp_lat, input bit noise);
    int c0;
    bit seen;
    @(negedge clk);
    sim_offset = s;
    bus.start  = 1'b1;
    c0         = cyc + 1;
    seen       = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (noise && $urandom_range(0, 15) == 0) bus.start = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", cyc - c0, exp_lat);
      check("final_cal_code", bus.cal_code, exp_cal);
      check("final_err", bus.err, exp_err);
      check("final_osc_en", bus.osc_en, 2'b00);
    end
  endtask

  initial begin
    int         c0;
    int         s;
    int         pn;
    logic [3:0] pc;
    logic       pe;

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_osc", bus.osc, 4'b1000);
    check("rst_osc_en", bus.osc_en, 2'b00);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_cal_code", bus.cal_code, 4'b1000);

    run_cal(12, 4'b0010, 1'b0, LAT1, 1'b0);
    run_cal(-12, 4'b1011, 1'b0, LAT2, 1'b0);
    run_cal(50, 4'b0111, 1'b1, LAT3, 1'b0);
    run_cal(-50, 4'b1111, 1'b1, LAT4, 1'b0);

    // Reset during the sampling window of the fourth code.
    @(negedge clk);
    sim_offset = -50;
    bus.start  = 1'b1;
    c0         = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < c0 + 3 * PER + SETTLE) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_osc", bus.osc, 4'b0100);
    rst = 1'b1;
    #1;
    check("mid_rst_osc", bus.osc, 4'b1000);
    check("mid_rst_osc_en", bus.osc_en, 2'b00);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cal(-12, 4'b1011, 1'b0, LAT2, 1'b0);

    for (int r = 0; r < 10; r++) begin
      s = int'($urandom_range(0, 120)) - 60;
      predict(s, pn, pc, pe);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_cal(s, pc, pe, pn * PER + 1, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
